// File: rtl/tlk2711_pkg.sv
// Shared constants and types for the TLK2711 transmit controller.
package tlk2711_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned LFSR_W = 15;
    localparam int unsigned CNT_W  = 16;

    localparam logic [WORD_W-1:0] K_COMMA = 16'hC5BC;
    localparam logic [WORD_W-1:0] K_SOF   = 16'h50FB;
    localparam logic [WORD_W-1:0] K_EOF   = 16'h50FD;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;

    typedef enum logic [1:0] {
        MODE_COMMA  = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_PRBS   = 2'd2,
        MODE_STREAM = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_SOF     = 3'd2,
        ST_SEQ     = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_EOF     = 3'd5,
        ST_GAP     = 3'd6
    } state_e;

    // x^15 + x^14 + 1, newest bit enters at bit 0
    function automatic logic [LFSR_W-1:0] prbs15_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[14] ^ s[13]};
    endfunction

endpackage

// File: rtl/tlk2711_tx_chan.sv
// One TLK2711 transmit channel: framing FSM, payload generators and frame counter.
// Pin-side outputs are registered, so they follow the FSM state by one cycle.
module tlk2711_tx_chan
    import tlk2711_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned SYNC_LEN  = 1024,
    parameter int unsigned IDLE_GAP  = 8,
    parameter int unsigned CH        = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        stop_ack,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] txd,
    output logic        tkmsb,
    output logic        tklsb,
    output logic        enable,
    output logic        lckrefn
);

    state_e              state, state_n;
    mode_e               mode_q;
    logic [CNT_W-1:0]    cnt;
    logic [LFSR_W-1:0]   lfsr;
    logic                ack_held;
    logic                go_c, pay_adv_c, ack_c, k_c;
    logic [WORD_W-1:0]   word_c;

    assign go_c      = (state == ST_IDLE) && start && !stop;
    // Stream payload only advances on a valid word; other modes advance every cycle
    assign pay_adv_c = (mode_q != MODE_STREAM) || s_valid;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:    if (go_c) state_n = ST_SYNC;
            ST_SYNC: begin
                if (stop)
                    state_n = ST_IDLE;
                else if (cnt == CNT_W'(SYNC_LEN - 1) && mode_q != MODE_COMMA)
                    state_n = ST_SOF;
            end
            ST_SOF:     state_n = ST_SEQ;
            ST_SEQ:     state_n = ST_PAYLOAD;
            ST_PAYLOAD: if (pay_adv_c && cnt == CNT_W'(FRAME_LEN - 1)) state_n = ST_EOF;
            ST_EOF:     state_n = stop ? ST_IDLE : ST_GAP;
            ST_GAP: begin
                if (stop)
                    state_n = ST_IDLE;
                else if (cnt == CNT_W'(IDLE_GAP - 1))
                    state_n = ST_SOF;
            end
            default:    state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        word_c = K_COMMA;
        k_c    = 1'b1;
        ack_c  = 1'b0;
        case (state)
            ST_SOF: word_c = K_SOF;
            ST_SEQ: begin
                word_c = frame_cnt;
                k_c    = 1'b0;
            end
            ST_PAYLOAD: begin
                case (mode_q)
                    MODE_COUNT: begin
                        word_c = cnt;
                        k_c    = 1'b0;
                    end
                    MODE_PRBS: begin
                        word_c = {1'b0, lfsr};
                        k_c    = 1'b0;
                    end
                    MODE_STREAM: begin
                        if (s_valid) begin
                            word_c = s_data;
                            k_c    = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            ST_EOF: word_c = K_EOF;
            default: ;
        endcase
        // A held stop acknowledges once; it re-arms when stop drops
        if (stop) begin
            case (state)
                ST_IDLE:                 ack_c = !ack_held;
                ST_SYNC, ST_GAP, ST_EOF: ack_c = 1'b1;
                default:                 ack_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_COMMA;
            cnt       <= '0;
            lfsr      <= '0;
            frame_cnt <= '0;
            ack_held  <= 1'b0;
        end else begin
            ack_held <= stop && (ack_held || ack_c);
            if (go_c) begin
                mode_q    <= mode_e'(mode);
                frame_cnt <= '0;
                lfsr      <= LFSR_SEED ^ LFSR_W'(CH);
            end else begin
                if (state == ST_EOF)
                    frame_cnt <= frame_cnt + 16'd1;
                if (state == ST_PAYLOAD && mode_q == MODE_PRBS)
                    lfsr <= prbs15_step(lfsr);
            end
            if (state_n != state)
                cnt <= '0;
            else if (state == ST_SYNC || state == ST_GAP || (state == ST_PAYLOAD && pay_adv_c))
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            txd      <= '0;
            tkmsb    <= 1'b0;
            tklsb    <= 1'b0;
            enable   <= 1'b0;
            lckrefn  <= 1'b0;
            busy     <= 1'b0;
            stop_ack <= 1'b0;
            s_ready  <= 1'b0;
        end else begin
            txd      <= word_c;
            tkmsb    <= 1'b0;
            tklsb    <= k_c;
            enable   <= 1'b1;
            lckrefn  <= 1'b1;
            busy     <= (state_n != ST_IDLE);
            stop_ack <= ack_c;
            s_ready  <= (state_n == ST_PAYLOAD) && (mode_q == MODE_STREAM);
        end
    end

endmodule

// File: rtl/tlk2711_tx_mc.sv
// Multi-channel TLK2711 transmit controller: one independent framing channel per device.
module tlk2711_tx_mc
    import tlk2711_pkg::*;
#(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned SYNC_LEN  = 1024,
    parameter int unsigned IDLE_GAP  = 8,
    parameter bit          LOOPEN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    i_start,
    input  logic [NUM_CH-1:0]    i_stop,
    input  logic [1:0]           i_mode,
    output logic [NUM_CH-1:0]    o_stop_ack,
    output logic [NUM_CH-1:0]    o_busy,
    input  logic [NUM_CH*16-1:0] s_data,
    input  logic [NUM_CH-1:0]    s_valid,
    output logic [NUM_CH-1:0]    s_ready,
    output logic [NUM_CH*16-1:0] o_frame_cnt,
    output logic [NUM_CH*16-1:0] o_txd,
    output logic [NUM_CH-1:0]    o_tkmsb,
    output logic [NUM_CH-1:0]    o_tklsb,
    output logic [NUM_CH-1:0]    o_enable,
    output logic [NUM_CH-1:0]    o_lckrefn,
    output logic [NUM_CH-1:0]    o_loopen,
    output logic [NUM_CH-1:0]    o_prbsen,
    output logic [NUM_CH-1:0]    o_testen
);

    assign o_loopen = {NUM_CH{LOOPEN}};
    assign o_prbsen = '0;
    assign o_testen = '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tlk2711_tx_chan #(
            .FRAME_LEN (FRAME_LEN),
            .SYNC_LEN  (SYNC_LEN),
            .IDLE_GAP  (IDLE_GAP),
            .CH        (g)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .start     (i_start[g]),
            .stop      (i_stop[g]),
            .mode      (i_mode),
            .s_data    (s_data[g*WORD_W +: WORD_W]),
            .s_valid   (s_valid[g]),
            .s_ready   (s_ready[g]),
            .stop_ack  (o_stop_ack[g]),
            .busy      (o_busy[g]),
            .frame_cnt (o_frame_cnt[g*WORD_W +: WORD_W]),
            .txd       (o_txd[g*WORD_W +: WORD_W]),
            .tkmsb     (o_tkmsb[g]),
            .tklsb     (o_tklsb[g]),
            .enable    (o_enable[g]),
            .lckrefn   (o_lckrefn[g])
        );
    end

endmodule

// File: tb/tb_tlk2711_tx_mc.sv
// Bench for tlk2711_tx_mc: expected pin streams are built as word sequences from the framing rules.
module tb_tlk2711_tx_mc;

    localparam int NCH = 2;
    localparam int FL = 4;
    localparam int SL = 2;
    localparam int IG = 3;
    localparam int MAXN = 64;
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_PAY = 2;
    localparam logic [15:0] COMMA = 16'hC5BC;
    localparam logic [15:0] SOFW = 16'h50FB;
    localparam logic [15:0] EOFW = 16'h50FD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NCH-1:0] i_start = '0, i_stop = '0, s_valid = '0;
    logic [1:0] i_mode = '0;
    logic [NCH*16-1:0] s_data = '0;
    logic [NCH-1:0] o_stop_ack, o_busy, s_ready, o_tkmsb, o_tklsb, o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen;
    logic [NCH*16-1:0] o_frame_cnt, o_txd;

    int checks = 0;
    int errors = 0;

    bit          valid_pat [NCH][MAXN+1];
    bit          stop_pat  [NCH][MAXN+1];
    logic [15:0] data_pat  [NCH][MAXN+1];
    logic [15:0] exp_w     [NCH][MAXN+1];
    bit          exp_k     [NCH][MAXN+1];
    int          exp_ph    [NCH][MAXN+1];
    bit          exp_ack   [NCH][MAXN+1];
    logic [15:0] got_w     [NCH][MAXN];
    logic [15:0] got_fc    [NCH][MAXN];
    logic        got_k     [NCH][MAXN];
    logic        got_ack   [NCH][MAXN];
    logic        got_busy  [NCH][MAXN];
    logic        got_rdy   [NCH][MAXN];

    tlk2711_tx_mc #(.NUM_CH(NCH), .FRAME_LEN(FL), .SYNC_LEN(SL), .IDLE_GAP(IG), .LOOPEN(1'b1)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_mode(i_mode),
        .o_stop_ack(o_stop_ack), .o_busy(o_busy), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .o_frame_cnt(o_frame_cnt), .o_txd(o_txd), .o_tkmsb(o_tkmsb),
        .o_tklsb(o_tklsb), .o_enable(o_enable), .o_lckrefn(o_lckrefn), .o_loopen(o_loopen),
        .o_prbsen(o_prbsen), .o_testen(o_testen)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_start = '0;
        i_stop  = '0;
        s_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic start_ch(input logic [1:0] mask, input int mode);
        i_mode  = 2'(mode);
        i_start = mask;
        tick();
        i_start = '0;
        i_mode  = 2'($urandom);
    endtask

    function automatic void put(int ch, int i, int ph, bit k, logic [15:0] w, bit a);
        if (i <= MAXN) begin
            exp_ph[ch][i]  = ph;
            exp_k[ch][i]   = k;
            exp_w[ch][i]   = w;
            exp_ack[ch][i] = a;
        end
    endfunction

    // Expected word sequence after a start: sync commas, frames, then idle commas once stopped
    task automatic build_expected(input int ch, input int mode, input int n);
        int i, cnt, fc, pidx;
        bit stopped, held, a;
        logic [15:0] w;
        logic [14:0] seed;
        bit bits[$];
        seed = 15'h7FFF ^ 15'(ch);
        bits = {};
        for (int b = 14; b >= 0; b--) bits.push_back(seed[b]);
        i = 0; fc = 0; pidx = 0; stopped = 0;
        for (int s = 0; (mode == 0 || s < SL) && i < n && !stopped; s++) begin
            put(ch, i, PH_BUSY, 1'b1, COMMA, stop_pat[ch][i]);
            stopped = stop_pat[ch][i];
            i++;
        end
        while (!stopped && i < n) begin
            put(ch, i, PH_BUSY, 1'b1, SOFW, 1'b0); i++;
            put(ch, i, PH_BUSY, 1'b0, fc[15:0], 1'b0); i++;
            cnt = 0;
            while (cnt < FL && i < n) begin
                if (mode == 3 && !valid_pat[ch][i]) begin
                    put(ch, i, PH_PAY, 1'b1, COMMA, 1'b0);
                end else begin
                    if (mode == 1) begin
                        w = 16'(cnt);
                    end else if (mode == 2) begin
                        w = '0;
                        for (int b = 0; b < 15; b++) w[14-b] = bits[pidx+b];
                        bits.push_back(bits[pidx] ^ bits[pidx+1]);
                        pidx++;
                    end else begin
                        w = data_pat[ch][i];
                    end
                    put(ch, i, PH_PAY, 1'b0, w, 1'b0);
                    cnt++;
                end
                i++;
            end
            if (i < n) begin
                put(ch, i, PH_BUSY, 1'b1, EOFW, stop_pat[ch][i]);
                fc++;
                stopped = stop_pat[ch][i];
                i++;
            end
            for (int g = 0; g < IG && i < n && !stopped; g++) begin
                put(ch, i, PH_BUSY, 1'b1, COMMA, stop_pat[ch][i]);
                stopped = stop_pat[ch][i];
                i++;
            end
        end
        held = stopped;
        while (i < n) begin
            a = stop_pat[ch][i] && !held;
            held = stop_pat[ch][i];
            put(ch, i, PH_IDLE, 1'b1, COMMA, a);
            i++;
        end
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                s_valid[ch] = valid_pat[ch][i];
                s_data[ch*16 +: 16] = data_pat[ch][i];
                i_stop[ch] = stop_pat[ch][i];
            end
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                got_w[ch][i]    = o_txd[ch*16 +: 16];
                got_fc[ch][i]   = o_frame_cnt[ch*16 +: 16];
                got_k[ch][i]    = o_tklsb[ch];
                got_ack[ch][i]  = o_stop_ack[ch];
                got_busy[ch][i] = o_busy[ch];
                got_rdy[ch][i]  = s_ready[ch];
            end
        end
        i_stop  = '0;
        s_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (o_txd !== '0 || o_tklsb !== '0 || o_tkmsb !== '0) begin
            errors++; $display("FAIL reset_words got txd=%h tk=%b/%b exp 0", o_txd, o_tkmsb, o_tklsb);
        end
        checks++;
        if ({o_enable, o_lckrefn, o_busy, o_stop_ack, s_ready} !== '0 || o_frame_cnt !== '0) begin
            errors++; $display("FAIL reset_ctrl got en=%b lck=%b busy=%b ack=%b rdy=%b fc=%h exp 0",
                               o_enable, o_lckrefn, o_busy, o_stop_ack, s_ready, o_frame_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (o_enable !== 2'b11 || o_lckrefn !== 2'b11) begin
            errors++; $display("FAIL release_en got en=%b lck=%b exp 11/11", o_enable, o_lckrefn);
        end
        checks++;
        if (o_txd !== {COMMA, COMMA} || o_tklsb !== 2'b11 || o_tkmsb !== 2'b00) begin
            errors++; $display("FAIL release_comma got txd=%h tk=%b/%b exp c5bcc5bc 00/11", o_txd, o_tkmsb, o_tklsb);
        end
        checks++;
        if (o_loopen !== 2'b11 || o_prbsen !== 2'b00 || o_testen !== 2'b00 || o_busy !== 2'b00) begin
            errors++; $display("FAIL static_pins got loop=%b prbs=%b test=%b busy=%b exp 11/00/00/00",
                               o_loopen, o_prbsen, o_testen, o_busy);
        end
    endtask

    task automatic test_traffic(input string name, input int mode, input logic [1:0] mask,
                                input int stop_at, input int stop_len, input bit hole,
                                input int n, input int vpct);
        int fc;
        for (int ch = 0; ch < NCH; ch++) begin
            for (int i = 0; i <= MAXN; i++) begin
                data_pat[ch][i]  = 16'($urandom);
                valid_pat[ch][i] = ($urandom_range(99) < vpct);
                stop_pat[ch][i]  = (stop_at >= 0 && i >= stop_at && i < stop_at + stop_len);
            end
            if (hole) begin
                for (int i = 0; i < SL + FL + 6; i++) valid_pat[ch][i] = 1'b1;
                valid_pat[ch][SL+3] = 1'b0;
                valid_pat[ch][SL+4] = 1'b0;
            end
        end
        do_reset();
        start_ch(mask, mode);
        capture(n);
        for (int ch = 0; ch < NCH; ch++) begin
            if (mask[ch]) begin
                build_expected(ch, mode, n + 1);
                fc = 0;
                for (int i = 0; i < n; i++) begin
                    if (exp_k[ch][i] && exp_w[ch][i] == EOFW) fc++;
                    checks++;
                    if (got_w[ch][i] !== exp_w[ch][i] || got_k[ch][i] !== exp_k[ch][i]) begin
                        errors++; $display("FAIL %s ch%0d word[%0d] got %h k=%b exp %h k=%b",
                                           name, ch, i, got_w[ch][i], got_k[ch][i], exp_w[ch][i], exp_k[ch][i]);
                    end
                    checks++;
                    if (got_ack[ch][i] !== exp_ack[ch][i]) begin
                        errors++; $display("FAIL %s ch%0d ack[%0d] got %b exp %b", name, ch, i, got_ack[ch][i], exp_ack[ch][i]);
                    end
                    checks++;
                    if (got_busy[ch][i] !== (exp_ph[ch][i+1] != PH_IDLE)) begin
                        errors++; $display("FAIL %s ch%0d busy[%0d] got %b exp %b", name, ch, i,
                                           got_busy[ch][i], exp_ph[ch][i+1] != PH_IDLE);
                    end
                    checks++;
                    if (got_rdy[ch][i] !== (exp_ph[ch][i+1] == PH_PAY && mode == 3)) begin
                        errors++; $display("FAIL %s ch%0d s_ready[%0d] got %b exp %b", name, ch, i,
                                           got_rdy[ch][i], exp_ph[ch][i+1] == PH_PAY && mode == 3);
                    end
                    checks++;
                    if (got_fc[ch][i] !== 16'(fc)) begin
                        errors++; $display("FAIL %s ch%0d frame_cnt[%0d] got %0d exp %0d", name, ch, i, got_fc[ch][i], fc);
                    end
                end
            end
        end
    endtask

    task automatic test_prbs_seeds();
        test_traffic("prbs", 2, 2'b11, -1, 0, 1'b0, 40, 100);
        checks++;
        if (got_w[0][SL+2] !== 16'h7FFF || got_w[1][SL+2] !== 16'h7FFE) begin
            errors++; $display("FAIL prbs_first got %h/%h exp 7fff/7ffe", got_w[0][SL+2], got_w[1][SL+2]);
        end
    endtask

    task automatic test_start_stop_idle();
        do_reset();
        i_start = 2'b01;
        i_stop  = 2'b01;
        tick();
        i_start = '0;
        checks++;
        if (o_stop_ack !== 2'b01 || o_busy !== 2'b00) begin
            errors++; $display("FAIL start_stop_ack got ack=%b busy=%b exp 01/00", o_stop_ack, o_busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (o_stop_ack !== 2'b00 || o_busy !== 2'b00 || o_txd !== {COMMA, COMMA}) begin
                errors++; $display("FAIL start_stop_hold[%0d] got ack=%b busy=%b txd=%h exp 00/00/c5bcc5bc",
                                   i, o_stop_ack, o_busy, o_txd);
            end
        end
        i_stop = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_ch(2'b11, 1);
        repeat (SL + 3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (o_txd !== '0 || o_tklsb !== '0 || {o_enable, o_lckrefn, o_busy, o_stop_ack, s_ready} !== '0 ||
            o_frame_cnt !== '0) begin
            errors++; $display("FAIL reset_mid got txd=%h tk=%b en=%b busy=%b fc=%h exp all 0",
                               o_txd, o_tklsb, o_enable, o_busy, o_frame_cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (o_txd !== {COMMA, COMMA} || o_busy !== 2'b00 || o_enable !== 2'b11) begin
                errors++; $display("FAIL after_reset_mid[%0d] got txd=%h busy=%b en=%b exp c5bcc5bc/00/11",
                                   i, o_txd, o_busy, o_enable);
            end
        end
    endtask

    initial begin
        test_reset();
        test_traffic("count", 1, 2'b01, -1, 0, 1'b0, 40, 100);
        test_traffic("stream", 3, 2'b01, -1, 0, 1'b1, 40, 70);
        test_traffic("stop_pay", 1, 2'b01, SL + 3, 6, 1'b0, 30, 100);
        test_traffic("stop_sync", 2, 2'b10, 1, 3, 1'b0, 20, 100);
        test_traffic("comma_only", 0, 2'b10, 20, 2, 1'b0, 30, 100);
        test_start_stop_idle();
        test_reset_mid();
        test_prbs_seeds();
        for (int r = 0; r < 6; r++) begin
            test_traffic("random", $urandom_range(1, 3), 2'($urandom_range(1, 3)),
                         $urandom_range(0, 40), $urandom_range(1, 5), 1'b0, 48, 60);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
